// File: rtl/timer_input_pkg.sv
// rtl/timer_input_pkg.sv - shared types and limits for the timer keypad entry path
package timer_input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_RELEASE  = 2'd3
    } entry_state_e;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // A digit may be shifted in only if it is BCD and the current seconds
    // digit can legally become the tens-of-seconds digit.
    function automatic logic digit_ok(input logic [3:0] code, input logic [3:0] cur_sec_ones);
        return (code <= BCD_MAX) && (cur_sec_ones <= SEC_TENS_MAX);
    endfunction

endpackage

// File: rtl/entry_shift_reg.sv
// rtl/entry_shift_reg.sv - 3-digit M:SS entry register with clear, shift, validity check and load
module entry_shift_reg
    import timer_input_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       accept_en,
    input  logic [3:0] code,
    input  logic       clear,
    input  logic       load_req,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       digit_strobe,
    output logic       key_reject,
    output logic       load_pulse
);

    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       strobe_q, strobe_d;
    logic       reject_q, reject_d;
    logic       load_pulse_q, load_pulse_d;
    logic       load_req_q, load_req_d;

    logic load_edge;
    logic shift_en;

    // A load on the same cycle as an accept wins, so the timer sees the pre-shift value.
    assign load_edge = load_req & ~load_req_q;
    assign shift_en  = accept_en & ~clear & ~load_edge;

    always_comb begin
        min_ones_d   = min_ones_q;
        sec_tens_d   = sec_tens_q;
        sec_ones_d   = sec_ones_q;
        strobe_d     = 1'b0;
        reject_d     = 1'b0;
        load_pulse_d = 1'b0;
        load_req_d   = load_req;

        if (clear) begin
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
        end else if (load_edge) begin
            load_pulse_d = (min_ones_q != 4'd0) || (sec_tens_q != 4'd0) || (sec_ones_q != 4'd0);
        end else if (shift_en) begin
            if (digit_ok(code, sec_ones_q)) begin
                min_ones_d = sec_tens_q;
                sec_tens_d = sec_ones_q;
                sec_ones_d = code;
                strobe_d   = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            min_ones_q   <= 4'd0;
            sec_tens_q   <= 4'd0;
            sec_ones_q   <= 4'd0;
            strobe_q     <= 1'b0;
            reject_q     <= 1'b0;
            load_pulse_q <= 1'b0;
            load_req_q   <= 1'b0;
        end else begin
            min_ones_q   <= min_ones_d;
            sec_tens_q   <= sec_tens_d;
            sec_ones_q   <= sec_ones_d;
            strobe_q     <= strobe_d;
            reject_q     <= reject_d;
            load_pulse_q <= load_pulse_d;
            load_req_q   <= load_req_d;
        end
    end

    assign min_ones     = min_ones_q;
    assign sec_tens     = sec_tens_q;
    assign sec_ones     = sec_ones_q;
    assign digit_strobe = strobe_q;
    assign key_reject   = reject_q;
    assign load_pulse   = load_pulse_q;

endmodule

// File: rtl/keypad_entry_controller.sv
// rtl/keypad_entry_controller.sv - keypad encoder sequencing, press/release debounce and time entry
module keypad_entry_controller
    import timer_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       entry_en,
    input  logic       clear,
    input  logic       load_req,
    input  logic       data_valid,
    input  logic [3:0] bcd_in,
    output logic       enable_n,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       digit_strobe,
    output logic       key_reject,
    output logic       load_pulse
);

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    entry_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             enable_n_q, enable_n_d;
    logic             accept_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        enable_n_d = ~entry_en;

        if (!entry_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_valid && !enable_n_q) begin
                        code_d  = bcd_in;
                        cnt_d   = CNT_ONE;
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!data_valid || (bcd_in != code_q)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_DONE) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_ACCEPT: begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
                ST_RELEASE: begin
                    // Only an unbroken run of released cycles returns to IDLE.
                    if (data_valid) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_DONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            code_q     <= 4'd0;
            enable_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            enable_n_q <= enable_n_d;
        end
    end

    assign accept_en = (state_q == ST_ACCEPT) && entry_en;
    assign enable_n  = enable_n_q;

    entry_shift_reg u_entry_shift_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .accept_en    (accept_en),
        .code         (code_q),
        .clear        (clear),
        .load_req     (load_req),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .digit_strobe (digit_strobe),
        .key_reject   (key_reject),
        .load_pulse   (load_pulse)
    );

endmodule
